// File: rtl/zero2asic_regbank.sv
// Host-bus register bank: NUM_REGS read/write byte registers plus a sticky
// write-1-to-clear status register with interrupt, on an asynchronous strobe bus.
module zero2asic_regbank #(
    parameter logic [15:0] BASE_ADDRESS = 16'hA000,
    parameter int          NUM_REGS     = 8,
    parameter logic [7:0]  RESET_VALUE  = 8'h00
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic                    write_strobe_b,
    input  logic                    read_strobe_b,
    input  logic [15:0]             address_bus,
    inout  wire  [7:0]              data_bus,
    output logic                    bus_dir,
    input  logic [7:0]              event_in,
    output logic [8*NUM_REGS-1:0]   reg_out,
    output logic [NUM_REGS-1:0]     wr_pulse,
    output logic                    irq
);

    localparam logic [16:0] BASE_EXT = {1'b0, BASE_ADDRESS};
    localparam logic [16:0] STAT_OFF = 17'(NUM_REGS);

    logic                ws_s1_r;
    logic                ws_s2_r;
    logic                ws_s3_r;
    logic [15:0]         addr_s1_r;
    logic [15:0]         addr_s2_r;
    logic [7:0]          data_s1_r;
    logic [7:0]          data_s2_r;
    logic                valid_r;
    logic                armed_r;
    logic [7:0]          regs_r [NUM_REGS];
    logic [7:0]          status_r;
    logic [7:0]          ev_q1_r;
    logic [7:0]          ev_q2_r;
    logic                irq_r;
    logic [NUM_REGS-1:0] wr_pulse_r;
    logic [7:0]          rd_q_r;

    logic [16:0]         wr_off_s;
    logic [16:0]         rd_off_s;
    logic                wr_event_s;
    logic [NUM_REGS-1:0] wr_hit_s;
    logic                wr_stat_s;
    logic [NUM_REGS-1:0] rd_sel_s;
    logic                rd_stat_s;
    logic                in_window_s;
    logic [7:0]          clr_s;
    logic [7:0]          rd_next_s;

    // Offsets wrap below the base into values with bit 16 set, so one compare bounds both ends.
    assign wr_off_s    = {1'b0, addr_s2_r} - BASE_EXT;
    assign rd_off_s    = {1'b0, address_bus} - BASE_EXT;
    assign wr_event_s  = armed_r & ws_s3_r & ~ws_s2_r;
    assign wr_stat_s   = wr_event_s & (wr_off_s == STAT_OFF);
    assign rd_stat_s   = (rd_off_s == STAT_OFF);
    assign in_window_s = (rd_off_s <= STAT_OFF);
    assign clr_s       = {8{wr_stat_s}} & data_s2_r;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        assign wr_hit_s[gi]         = wr_event_s & (wr_off_s == 17'(gi));
        assign rd_sel_s[gi]         = (rd_off_s == 17'(gi));
        assign reg_out[8*gi +: 8]   = regs_r[gi];
    end

    // Read data mux: one-hot select OR-reduced across registers and status.
    always_comb begin
        rd_next_s = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_next_s = rd_next_s | ({8{rd_sel_s[i]}} & regs_r[i]);
        end
        rd_next_s = rd_next_s | ({8{rd_stat_s}} & status_r);
    end

    // Host write synchroniser; armed only after the strobe is seen high post-reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ws_s1_r   <= 1'b1;
            ws_s2_r   <= 1'b1;
            ws_s3_r   <= 1'b1;
            addr_s1_r <= 16'h0000;
            addr_s2_r <= 16'h0000;
            data_s1_r <= 8'h00;
            data_s2_r <= 8'h00;
            valid_r   <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            ws_s1_r   <= write_strobe_b;
            ws_s2_r   <= ws_s1_r;
            ws_s3_r   <= ws_s2_r;
            addr_s1_r <= address_bus;
            addr_s2_r <= addr_s1_r;
            data_s1_r <= data_bus;
            data_s2_r <= data_s1_r;
            valid_r   <= 1'b1;
            armed_r   <= armed_r | (valid_r & ws_s1_r);
        end
    end

    // Read/write register file and per-register commit pulses.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VALUE;
            end
            wr_pulse_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit_s[i]) begin
                    regs_r[i] <= data_s2_r;
                end
            end
            wr_pulse_r <= wr_hit_s;
        end
    end

    // Sticky status: event rising edges set, W1C clears, set takes priority.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ev_q1_r  <= 8'h00;
            ev_q2_r  <= 8'h00;
            status_r <= 8'h00;
            irq_r    <= 1'b0;
        end else begin
            ev_q1_r  <= event_in;
            ev_q2_r  <= ev_q1_r;
            status_r <= (status_r & ~clr_s) | (ev_q1_r & ~ev_q2_r);
            irq_r    <= |status_r;
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rd_q_r <= 8'h00;
        end else begin
            rd_q_r <= rd_next_s;
        end
    end

    assign bus_dir  = reset_b & ~read_strobe_b & in_window_s;
    assign data_bus = bus_dir ? rd_q_r : 8'hzz;
    assign wr_pulse = wr_pulse_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_zero2asic_regbank.sv
// Randomised bench for zero2asic_regbank against an array-based model of the
// register map, status stickiness and write timing.
module tb_zero2asic_regbank;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        write_strobe_b;
    logic        read_strobe_b;
    logic [15:0] address_bus;
    wire  [7:0]  data_bus;
    logic        bus_dir;
    logic [7:0]  event_in;
    logic [63:0] reg_out;
    logic [7:0]  wr_pulse;
    logic        irq;

    logic [7:0]  data_drv;
    logic        drive_en;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulse_total = 0;

    logic [7:0]  m_regs [8];
    logic [7:0]  m_status;
    logic [7:0]  m_ev;

    assign data_bus = drive_en ? data_drv : 8'hzz;

    zero2asic_regbank dut (
        .clk(clk), .reset_b(reset_b), .write_strobe_b(write_strobe_b),
        .read_strobe_b(read_strobe_b), .address_bus(address_bus), .data_bus(data_bus),
        .bus_dir(bus_dir), .event_in(event_in), .reg_out(reg_out),
        .wr_pulse(wr_pulse), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) pulse_total <= pulse_total + $countones(wr_pulse);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_regs();
        logic [63:0] v = 64'h0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    function automatic logic [7:0] one_hot(input int idx);
        logic [7:0] v = 8'h00;
        if (idx >= 0 && idx < 8) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_status = 8'h00;
    endtask

    // Host write; optionally changes event_in so its set lands on the commit edge.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int len,
                            input logic [7:0] ev_val, input bit ev_en);
        int off = int'(a) - 32'hA000;
        int idx = (off >= 0 && off < 8) ? off : -1;
        int p0;
        @(negedge clk);
        address_bus = a; data_drv = d; drive_en = 1'b1;
        @(negedge clk);
        p0 = pulse_total;
        write_strobe_b = 1'b0;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            if (ev_en && i == 1) event_in = ev_val;
            if (i == 2) check_eq("wr_pulse_early", {56'h0, wr_pulse}, 64'h0);
            if (i == 3) begin
                if (idx >= 0) m_regs[idx] = d;
                if (off == 8) m_status = m_status & ~d;
                if (ev_en) begin
                    m_status = m_status | (ev_val & ~m_ev);
                    m_ev = ev_val;
                end
                check_eq("wr_pulse_timing", {56'h0, wr_pulse}, {56'h0, one_hot(idx)});
                check_eq("reg_out_after_write", reg_out, model_regs());
            end
        end
        write_strobe_b = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("wr_pulse_count", 64'(pulse_total - p0), (idx >= 0) ? 64'd1 : 64'd0);
        check_eq("irq_after_write", {63'h0, irq}, {63'h0, |m_status});
        drive_en = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a);
        int off = int'(a) - 32'hA000;
        logic [7:0] exp;
        @(negedge clk);
        address_bus = a; drive_en = 1'b0; read_strobe_b = 1'b0;
        #1;
        check_eq("bus_dir", {63'h0, bus_dir}, (off >= 0 && off <= 8) ? 64'd1 : 64'd0);
        repeat (2) @(negedge clk);
        exp = (off >= 0 && off < 8) ? m_regs[off] : (off == 8) ? m_status : 8'h00;
        if (off >= 0 && off <= 8) check_eq("read_data", {56'h0, data_bus}, {56'h0, exp});
        read_strobe_b = 1'b1;
    endtask

    task automatic do_event(input logic [7:0] v);
        @(negedge clk);
        event_in = v;
        m_status = m_status | (v & ~m_ev);
        m_ev = v;
        repeat (3) @(negedge clk);
        check_eq("irq_after_event", {63'h0, irq}, {63'h0, |m_status});
    endtask

    initial begin
        int p0;
        logic [15:0] ra;
        reset_b = 1'b0; write_strobe_b = 1'b1; read_strobe_b = 1'b0;
        address_bus = 16'hA003; data_drv = 8'h00; drive_en = 1'b0;
        event_in = 8'h00; m_ev = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("reset_bus_dir", {63'h0, bus_dir}, 64'h0);
        check_eq("reset_reg_out", reg_out, 64'h0);
        check_eq("reset_wr_pulse", {56'h0, wr_pulse}, 64'h0);
        check_eq("reset_irq", {63'h0, irq}, 64'h0);
        reset_b = 1'b1; read_strobe_b = 1'b1;
        repeat (3) @(negedge clk);
        do_read(16'hA003);

        do_write(16'hA002, 8'h5A, 10, 8'h00, 1'b0);
        check_eq("reg2_5a", {56'h0, reg_out[23:16]}, 64'h5A);
        do_read(16'hA002);
        do_write(16'hA008, 8'hFF, 4, 8'h00, 1'b0);
        do_write(16'h9FFF, 8'hFF, 4, 8'h00, 1'b0);
        do_read(16'h9FFF);
        do_read(16'hA008);

        do_event(8'h21);
        do_event(8'h00);
        do_read(16'hA008);
        do_write(16'hA008, 8'h01, 3, 8'h00, 1'b0);
        do_read(16'hA008);
        do_write(16'hA008, 8'h20, 3, 8'h00, 1'b0);
        do_read(16'hA008);

        do_event(8'h08);
        do_event(8'h00);
        do_write(16'hA008, 8'h08, 5, 8'h08, 1'b1);
        check_eq("set_beats_clear", {63'h0, m_status[3]}, 64'd1);
        do_read(16'hA008);
        do_event(8'h00);

        do_write(16'hA001, 8'h77, 3, 8'h00, 1'b0);
        @(negedge clk);
        address_bus = 16'hA001; data_drv = 8'hC3; drive_en = 1'b1;
        @(negedge clk);
        p0 = pulse_total;
        write_strobe_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (6) @(negedge clk);
        write_strobe_b = 1'b1;
        repeat (4) @(negedge clk);
        drive_en = 1'b0;
        check_eq("midwrite_reg1", {56'h0, reg_out[15:8]}, 64'h00);
        check_eq("midwrite_pulses", 64'(pulse_total - p0), 64'd0);
        do_write(16'hA001, 8'hC3, 3, 8'h00, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int op = $urandom_range(0, 3);
            int r  = $urandom_range(0, 11);
            ra = (r <= 8) ? 16'(32'hA000 + r) : (r == 9) ? 16'h9FFF :
                 (r == 10) ? 16'hA009 : 16'($urandom);
            case (op)
                0, 1: do_write(ra, 8'($urandom), $urandom_range(3, 8), 8'h00, 1'b0);
                2:    do_read(ra);
                default: do_event(8'($urandom));
            endcase
        end
        for (int i = 0; i <= 8; i++) do_read(16'(32'hA000 + i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
